// File: rtl/mem_ctrl_pkg.sv
// Shared types and encodings for the byte-serial memory controller.
//   MEM_* : mem_cnf access-size encodings
//   state_t : controller sequencing states
//   owner_t : which requester the current transaction belongs to
//   cnf_bytes() : number of byte beats for a given access size
package mem_ctrl_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic [1:0] MEM_NONE = 2'd0;
  localparam logic [1:0] MEM_B    = 2'd1;
  localparam logic [1:0] MEM_H    = 2'd2;
  localparam logic [1:0] MEM_W    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_DONE
  } state_t;

  typedef enum logic {
    OWN_IF,
    OWN_MEM
  } owner_t;

  typedef logic [3:0][BYTE_W-1:0] byte_word_t;

  function automatic logic [2:0] cnf_bytes(input logic [1:0] cnf);
    logic [2:0] n;
    case (cnf)
      MEM_B:   n = 3'd1;
      MEM_H:   n = 3'd2;
      MEM_W:   n = 3'd4;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates one byte-wide RAM port between instruction fetch and
// the MEM stage. Loads/stores of 1/2/4 bytes are serialised into byte beats;
// load bytes are assembled little-endian and zero/sign-extended. MEM requests
// have fixed priority over IF. Completion is a one-cycle done pulse.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   if_req/if_addr/if_flush  fetch request, address, branch abort
//   if_done/if_inst          fetch completion pulse and fetched word
//   mem_req/mem_wr/mem_cnf/mem_signed/mem_addr/mem_wdata  MEM-stage access
//   mem_done/mem_rdata       access completion pulse and extended load data
//   ram_addr/ram_wr/ram_dout byte RAM address, write strobe, write byte
//   ram_din                  byte RAM read data, one cycle after ram_addr
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  input  logic                  if_flush,
  output logic                  if_done,
  output logic [31:0]           if_inst,
  input  logic                  mem_req,
  input  logic                  mem_wr,
  input  logic [1:0]            mem_cnf,
  input  logic                  mem_signed,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_wdata,
  output logic                  mem_done,
  output logic [31:0]           mem_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_wr,
  output logic [BYTE_W-1:0]     ram_dout,
  input  logic [BYTE_W-1:0]     ram_din
);

  state_t     state;
  owner_t     owner;
  logic [2:0] cnt;
  logic [2:0] n_q;
  logic [1:0] cnf_q;
  logic       sgn_q;
  logic [31:0] wdata_q;
  byte_word_t bytes_q;

  logic [1:0] byte_idx;
  byte_word_t asm_word;
  logic [31:0] load_word;

  // Read data lags the address by one cycle, so the byte arriving while the
  // counter reads cnt belongs to position cnt-1.
  assign byte_idx = cnt[1:0] - 2'd1;

  // Final assembly folds in the last byte straight from ram_din so the result
  // can be registered on the same edge that enters DONE.
  always_comb begin
    asm_word           = bytes_q;
    asm_word[byte_idx] = ram_din;
    case (cnf_q)
      MEM_B:   load_word = {{24{asm_word[0][7] & sgn_q}}, asm_word[0]};
      MEM_H:   load_word = {{16{asm_word[1][7] & sgn_q}}, asm_word[1], asm_word[0]};
      default: load_word = asm_word;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      owner     <= OWN_IF;
      cnt       <= '0;
      n_q       <= '0;
      cnf_q     <= MEM_NONE;
      sgn_q     <= 1'b0;
      wdata_q   <= '0;
      bytes_q   <= '0;
      if_done   <= 1'b0;
      if_inst   <= '0;
      mem_done  <= 1'b0;
      mem_rdata <= '0;
      ram_addr  <= '0;
      ram_wr    <= 1'b0;
      ram_dout  <= '0;
    end else begin
      if_done  <= 1'b0;
      mem_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt     <= '0;
          bytes_q <= '0;
          if (mem_req && mem_cnf != MEM_NONE) begin
            owner    <= OWN_MEM;
            cnf_q    <= mem_cnf;
            n_q      <= cnf_bytes(mem_cnf);
            sgn_q    <= mem_signed;
            wdata_q  <= mem_wdata;
            ram_addr <= mem_addr;
            if (mem_wr) begin
              state    <= ST_WRITE;
              ram_wr   <= 1'b1;
              ram_dout <= mem_wdata[BYTE_W-1:0];
            end else begin
              state <= ST_READ;
            end
          end else if (if_req && !if_flush) begin
            owner    <= OWN_IF;
            cnf_q    <= MEM_W;
            n_q      <= 3'd4;
            sgn_q    <= 1'b0;
            ram_addr <= if_addr;
            state    <= ST_READ;
          end
        end

        ST_READ: begin
          if (owner == OWN_IF && if_flush) begin
            state <= ST_IDLE;
          end else begin
            if (cnt != 3'd0) bytes_q[byte_idx] <= ram_din;
            if (cnt == n_q) begin
              state <= ST_DONE;
              if (owner == OWN_MEM) begin
                mem_done  <= 1'b1;
                mem_rdata <= load_word;
              end else begin
                if_done <= 1'b1;
                if_inst <= load_word;
              end
            end else begin
              cnt <= cnt + 3'd1;
              if (cnt + 3'd1 < n_q) ram_addr <= ram_addr + ADDR_WIDTH'(1);
            end
          end
        end

        ST_WRITE: begin
          if (cnt == n_q - 3'd1) begin
            state    <= ST_DONE;
            ram_wr   <= 1'b0;
            mem_done <= 1'b1;
          end else begin
            cnt      <= cnt + 3'd1;
            ram_addr <= ram_addr + ADDR_WIDTH'(1);
            ram_dout <= wdata_q[{cnt[1:0] + 2'd1, 3'b000} +: BYTE_W];
          end
        end

        ST_DONE: state <= ST_IDLE;

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed corner cases followed by a
// randomized mix of loads, stores and fetches, all checked against a
// byte-array memory model and per-access latency rules.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_flush, if_done;
  logic [31:0] if_addr, if_inst;
  logic        mem_req, mem_wr, mem_signed, mem_done;
  logic [1:0]  mem_cnf;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] ram_addr;
  logic        ram_wr;
  logic [7:0]  ram_dout, ram_din;

  mem_ctrl #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_done(if_done), .if_inst(if_inst),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_cnf(mem_cnf), .mem_signed(mem_signed),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata),
    .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int if_pulses = 0, mem_pulses = 0;
  int exp_if = 0, exp_mem = 0;

  logic [7:0]  ram    [logic [31:0]];
  logic [7:0]  shadow [logic [31:0]];
  logic [39:0] beats  [$];

  function automatic logic [7:0] dflt(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  function automatic logic [7:0] rd_ram(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : dflt(a);
  endfunction

  function automatic logic [7:0] rd_shadow(input logic [31:0] a);
    return shadow.exists(a) ? shadow[a] : dflt(a);
  endfunction

  function automatic int nbytes(input logic [1:0] cnf);
    return (cnf == 2'd1) ? 1 : (cnf == 2'd2) ? 2 : 4;
  endfunction

  // Little-endian value of n bytes, optionally sign-extended to 32 bits.
  function automatic logic [31:0] model_load(input logic [31:0] a, input int n, input bit sgn);
    longint v = 0;
    logic [31:0] ai;
    for (int i = 0; i < n; i++) begin
      ai = a + 32'(i);
      v += longint'(rd_shadow(ai)) << (8 * i);
    end
    if (sgn && n < 4 && v >= (longint'(1) << (8 * n - 1)))
      v -= longint'(1) << (8 * n);
    return v[31:0];
  endfunction

  task automatic poke(input logic [31:0] a, input logic [7:0] d);
    ram[a]    = d;
    shadow[a] = d;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Byte RAM: registered read, one cycle of latency.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    ram_din <= rd_ram(ram_addr);
    if (ram_wr) begin
      ram[ram_addr] = ram_dout;
      beats.push_back({ram_addr, ram_dout});
    end
  end

  always @(negedge clk) begin
    if (if_done)  if_pulses++;
    if (mem_done) mem_pulses++;
  end

  task automatic do_mem(input bit wr, input logic [1:0] cnf, input bit sgn,
                        input logic [31:0] a, input logic [31:0] wd, input string tag);
    int t0, n, lat;
    logic [31:0] ai;
    n = nbytes(cnf);
    lat = -1;
    beats.delete();
    mem_req = 1'b1; mem_wr = wr; mem_cnf = cnf; mem_signed = sgn;
    mem_addr = a; mem_wdata = wd;
    t0 = cyc;
    for (int k = 0; k < 20 && lat < 0; k++) begin
      @(negedge clk);
      if (mem_done) lat = cyc - t0;
    end
    mem_req = 1'b0;
    check({tag, "_lat"}, 64'(lat), wr ? 64'(n + 1) : 64'(n + 2));
    if (lat >= 0) exp_mem++;
    if (wr) begin
      check({tag, "_nbeats"}, 64'(beats.size()), 64'(n));
      for (int i = 0; i < n && i < beats.size(); i++) begin
        ai = a + 32'(i);
        check({tag, "_beat"}, 64'(beats[i]), 64'({ai, 8'(wd >> (8 * i))}));
      end
      for (int i = 0; i < n; i++) begin
        ai = a + 32'(i);
        shadow[ai] = 8'(wd >> (8 * i));
      end
    end else begin
      check({tag, "_data"}, 64'(mem_rdata), 64'(model_load(a, n, sgn)));
      check({tag, "_nowr"}, 64'(beats.size()), 64'd0);
    end
    @(negedge clk);
  endtask

  task automatic do_if(input logic [31:0] a, input string tag);
    int t0, lat;
    lat = -1;
    if_req = 1'b1; if_addr = a;
    t0 = cyc;
    for (int k = 0; k < 20 && lat < 0; k++) begin
      @(negedge clk);
      if (if_done) lat = cyc - t0;
    end
    if_req = 1'b0;
    check({tag, "_lat"}, 64'(lat), 64'd6);
    if (lat >= 0) exp_if++;
    check({tag, "_inst"}, 64'(if_inst), 64'(model_load(a, 4, 1'b0)));
    @(negedge clk);
  endtask

  initial begin
    int t0, dm, di;
    logic [31:0] a;
    rst = 1'b1;
    if_req = 0; if_addr = 0; if_flush = 0;
    mem_req = 0; mem_wr = 0; mem_cnf = 0; mem_signed = 0; mem_addr = 0; mem_wdata = 0;
    repeat (3) @(negedge clk);
    check("reset_outs", 64'({if_done, mem_done, ram_wr, ram_dout}), 64'd0);
    check("reset_data", 64'({if_inst, mem_rdata}), 64'd0);
    check("reset_addr", 64'(ram_addr), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed loads
    poke(32'h100, 8'h11); poke(32'h101, 8'h22); poke(32'h102, 8'h33); poke(32'h103, 8'h44);
    do_mem(0, 2'd3, 0, 32'h100, 0, "lw_100");
    check("lw_100_value", 64'(mem_rdata), 64'h44332211);
    poke(32'h200, 8'h80);
    do_mem(0, 2'd1, 1, 32'h200, 0, "lb_s");
    check("lb_s_value", 64'(mem_rdata), 64'hFFFFFF80);
    do_mem(0, 2'd1, 0, 32'h200, 0, "lbu");
    check("lbu_value", 64'(mem_rdata), 64'h00000080);
    poke(32'h210, 8'hFF); poke(32'h211, 8'h7F);
    do_mem(0, 2'd2, 1, 32'h210, 0, "lh_s");
    check("lh_s_value", 64'(mem_rdata), 64'h00007FFF);

    // Halfword store
    do_mem(1, 2'd2, 0, 32'h300, 32'hABCD1234, "sh_300");
    check("sh_302_untouched", 64'(rd_ram(32'h302)), 64'(dflt(32'h302)));

    // mem_req with no size is ignored, IF is served instead
    mem_req = 1'b1; mem_cnf = 2'd0;
    beats.delete();
    repeat (5) @(negedge clk);
    check("cnf0_ignored", 64'({mem_pulses, if_pulses}), 64'({exp_mem, exp_if}));
    do_if(32'h100, "if_cnf0");
    mem_req = 1'b0;

    // Simultaneous requests: MEM first, IF accepted the cycle after MEM DONE
    poke(32'h400, 8'hDE); poke(32'h401, 8'hAD); poke(32'h402, 8'hBE); poke(32'h403, 8'hEF);
    mem_req = 1; mem_wr = 0; mem_cnf = 2'd3; mem_signed = 0; mem_addr = 32'h100;
    if_req = 1; if_addr = 32'h400;
    t0 = cyc; dm = -1; di = -1;
    for (int k = 0; k < 30 && di < 0; k++) begin
      @(negedge clk);
      if (mem_done && dm < 0) begin dm = cyc; mem_req = 0; end
      if (if_done) begin di = cyc; if_req = 0; end
    end
    mem_req = 0; if_req = 0;
    check("prio_mem_lat", 64'(dm - t0), 64'd6);
    check("prio_if_gap", 64'(di - dm), 64'd7);
    check("prio_mem_data", 64'(mem_rdata), 64'h44332211);
    check("prio_if_inst", 64'(if_inst), 64'hEFBEADDE);
    if (dm >= 0) exp_mem++;
    if (di >= 0) exp_if++;
    @(negedge clk);

    // Flush in T+2: no if_done, controller idle in T+3 (MEM accepted there)
    if_req = 1; if_addr = 32'h100;
    @(negedge clk);
    @(negedge clk);
    if_flush = 1; if_req = 0;
    @(negedge clk);
    if_flush = 0;
    do_mem(0, 2'd1, 0, 32'h200, 0, "after_flush");
    repeat (3) @(negedge clk);
    check("flush_no_if_done", 64'(if_pulses), 64'(exp_if));
    do_if(32'h400, "if_new_pc");

    // Reset during second store beat
    beats.delete();
    mem_req = 1; mem_wr = 1; mem_cnf = 2'd3; mem_addr = 32'h500; mem_wdata = 32'h87654321;
    @(negedge clk);
    @(negedge clk);
    rst = 1; mem_req = 0;
    @(negedge clk);
    check("rst_ram_wr", 64'(ram_wr), 64'd0);
    check("rst_outs", 64'({mem_done, mem_rdata, if_inst}), 64'd0);
    rst = 0;
    repeat (4) @(negedge clk);
    check("rst_no_done", 64'(mem_pulses), 64'(exp_mem));
    check("rst_nbeats", 64'(beats.size()), 64'd2);
    check("rst_502_untouched", 64'({rd_ram(32'h502), rd_ram(32'h503)}),
          64'({dflt(32'h502), dflt(32'h503)}));
    shadow[32'h500] = 8'h21; shadow[32'h501] = 8'h43;

    // Address wrap
    poke(32'hFFFFFFFE, 8'hA1); poke(32'hFFFFFFFF, 8'hB2); poke(32'h0, 8'hC3); poke(32'h1, 8'hD4);
    do_mem(0, 2'd3, 0, 32'hFFFFFFFE, 0, "lw_wrap");
    check("lw_wrap_value", 64'(mem_rdata), 64'hD4C3B2A1);

    // Randomized traffic
    for (int it = 0; it < 80; it++) begin
      a = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3))
                                      : 32'h1000 + 32'($urandom_range(0, 63));
      case ($urandom_range(0, 2))
        0: do_mem(0, 2'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), a, 0, "rnd_ld");
        1: do_mem(1, 2'($urandom_range(1, 3)), 0, a, $urandom, "rnd_st");
        default: do_if(a, "rnd_if");
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    check("total_if_pulses", 64'(if_pulses), 64'(exp_if));
    check("total_mem_pulses", 64'(mem_pulses), 64'(exp_mem));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
